// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the link transmitter.
// Receiver state encoding plus sizing helpers for frame and counter widths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  // Number of packets that make up one parallel word.
  function automatic int num_words(input int w_out, input int bits_per_word);
    return w_out / bits_per_word;
  endfunction

  // Bit periods occupied by one packet on the line.
  function automatic int packet_bits(input int bits_per_word, input int stop_bits);
    return 1 + bits_per_word + stop_bits;
  endfunction

  // Counter width able to index n values, never narrower than one bit.
  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL sets the value both flops take during reset.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // Double-register the async input to settle metastability.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: gathers NUM_WORDS packets (word 0 first) into one wide word
// presented on a valid/ready port. A new frame arriving while the previous one
// is still unconsumed is dropped and flagged on m_error.
// Optional: define UART_RX_FRAME_CHECK_EN to discard the partial frame and
// flag m_error when a stop bit samples low.
module uart_rx
  import uart_pkg::*;
#(
  parameter  int CLOCKS_PER_PULSE = 4,
  parameter  int BITS_PER_WORD    = 8,
  parameter  int W_OUT            = 24,
  localparam int NUM_WORDS        = num_words(W_OUT, BITS_PER_WORD)
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      rx,
  output logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]   m_data,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic                                      m_error
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(BITS_PER_WORD + 1);
  localparam int WW = ctr_w(NUM_WORDS);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(BITS_PER_WORD - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

  uart_rx_state_t state, state_n;

  logic                                    rx_s;
  logic                                    stop_ok;
  logic [CW-1:0]                           c_clocks;
  logic [BW-1:0]                           c_bits;
  logic [WW-1:0]                           c_words;
  logic [BITS_PER_WORD-1:0]                shift;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] word_buf;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] frame;
  logic                                    tick_half, tick_full;
  logic                                    clr_clocks, shift_en, word_done, frame_err;
  logic                                    frame_done;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_FRAME_CHECK_EN
  assign stop_ok = rx_s;
`else
  assign stop_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode and per-cycle strobes for the counters and datapath.
  always_comb begin
    state_n    = state;
    tick_half  = (c_clocks == HALF_LAST);
    tick_full  = (c_clocks == FULL_LAST);
    clr_clocks = 1'b0;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n    = START;
          clr_clocks = 1'b1;
        end
      end
      START: begin
        if (tick_half) begin
          clr_clocks = 1'b1;
          state_n    = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_full) begin
          clr_clocks = 1'b1;
          shift_en   = 1'b1;
          if (c_bits == BITS_LAST) state_n = STOP;
        end
      end
      STOP: begin
        if (tick_full) begin
          clr_clocks = 1'b1;
          state_n    = IDLE;
          if (stop_ok) word_done = 1'b1;
          else         frame_err = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign frame_done = word_done && (c_words == WORD_LAST);

  // Completed frame: buffered earlier words plus the word just shifted in.
  always_comb begin
    frame              = word_buf;
    frame[NUM_WORDS-1] = shift;
  end

  // Bit-timing, bit and word counters with the receive shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_clocks <= '0;
      c_bits   <= '0;
      c_words  <= '0;
      shift    <= '0;
      word_buf <= '0;
    end else begin
      if (clr_clocks)          c_clocks <= '0;
      else if (state != IDLE)  c_clocks <= c_clocks + 1'b1;

      if (shift_en) begin
        shift  <= BITS_PER_WORD'({rx_s, shift} >> 1);
        c_bits <= (c_bits == BITS_LAST) ? '0 : c_bits + 1'b1;
      end

      if (word_done) begin
        word_buf[c_words] <= shift;
        c_words           <= (c_words == WORD_LAST) ? '0 : c_words + 1'b1;
      end else if (frame_err) begin
        c_words <= '0;
      end
    end
  end

  // Output port: load on a free or draining slot, otherwise drop and flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_error <= 1'b0;
    end else begin
      m_error <= frame_err;
      if (frame_done && (!m_valid || m_ready)) begin
        m_data  <= frame;
        m_valid <= 1'b1;
      end else begin
        if (frame_done)          m_error <= 1'b1;
        if (m_valid && m_ready)  m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx with default parameters (4 clocks/bit, 8 bits, 24-bit frame).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPP = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            rx = 1'b1;
  logic            m_ready = 1'b0;
  logic [2:0][7:0] m_data;
  logic            m_valid;
  logic            m_error;

  uart_rx #(
    .CLOCKS_PER_PULSE (CPP),
    .BITS_PER_WORD    (8),
    .W_OUT            (24)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx      (rx),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_error (m_error)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          valid_cycles = 0;
  int          err_cycles = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expected frame at every accepted handshake.
  always @(negedge clk) begin
    if (m_valid) valid_cycles++;
    if (m_error) err_cycles++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: got 0x%0h, expected no frame", m_data);
      end else begin
        check("frame_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input int cycles);
    rx = b;
    wait_cycles(cycles);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_val, input int nstop);
    drive(1'b0, CPP);
    for (int i = 0; i < 8; i++) drive(d[i], CPP);
    drive(stop_val, CPP);
    if (nstop > 1) drive(1'b1, CPP * (nstop - 1));
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [2:0][7:0] b, input int nstop);
    for (int i = 0; i < 3; i++) send_byte(b[i], 1'b1, nstop);
  endtask

  typedef struct {
    logic [2:0][7:0] bytes;   // bytes[0] is sent first
    int              nstop;
    logic [23:0]     exp_data;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int v0, e0, err_exp;
`ifdef UART_RX_FRAME_CHECK_EN
    localparam int FRAME_CHECK = 1;
`else
    localparam int FRAME_CHECK = 0;
`endif
    vecs[0] = '{bytes: {8'h0F, 8'h3C, 8'hA5}, nstop: 1, exp_data: 24'h0F3CA5};
    vecs[1] = '{bytes: {8'h12, 8'h34, 8'h56}, nstop: 4, exp_data: 24'h123456};
    vecs[2] = '{bytes: {8'hAB, 8'hCD, 8'hEF}, nstop: 4, exp_data: 24'hABCDEF};
    vecs[3] = '{bytes: {8'h80, 8'hFF, 8'h00}, nstop: 1, exp_data: 24'h80FF00};
    err_exp = 0;

    // Reset state
    wait_cycles(3);
    check("reset_m_valid", 32'(m_valid), 32'h0);
    check("reset_m_error", 32'(m_error), 32'h0);
    check("reset_m_data",  32'(m_data),  32'h0);
    rstn = 1'b1;
    wait_cycles(5);

    // Table-driven frames with the consumer always ready
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[i].exp_data);
      valid_cycles = 0;
      send_frame(vecs[i].bytes, vecs[i].nstop);
      wait_cycles(10);
      check("valid_width", 32'(valid_cycles), 32'd1);
    end
    check("table_pending", 32'(exp_q.size()), 32'd0);

    // Glitch between word 0 and word 1 must not disturb the frame
    exp_q.push_back(24'hCCBBAA);
    send_byte(8'hAA, 1'b1, 1);
    wait_cycles(4);
    v0 = valid_cycles;
    drive(1'b0, 1);
    drive(1'b1, 20);
    check("glitch_no_valid", 32'(valid_cycles), 32'(v0));
    send_byte(8'hBB, 1'b1, 1);
    send_byte(8'hCC, 1'b1, 1);
    wait_cycles(10);
    check("glitch_pending", 32'(exp_q.size()), 32'd0);

    // Stop bit low on byte 1
    e0 = err_cycles;
    if (FRAME_CHECK != 0) begin
      exp_q.push_back(24'h030201);
    end else begin
      exp_q.push_back(24'h017799);
      exp_q.push_back(24'h040302);
    end
    send_byte(8'h99, 1'b1, 1);
    send_byte(8'h77, 1'b0, 1);
    drive(1'b1, 3 * CPP);
    send_byte(8'h01, 1'b1, 1);
    send_byte(8'h02, 1'b1, 1);
    send_byte(8'h03, 1'b1, 1);
    if (FRAME_CHECK == 0) send_byte(8'h04, 1'b1, 1);
    wait_cycles(10);
    check("stopbit_err_count", 32'(err_cycles - e0), 32'(FRAME_CHECK));
    check("stopbit_pending", 32'(exp_q.size()), 32'd0);
    err_exp += FRAME_CHECK;

    // Backpressure: second frame dropped with one error pulse
    m_ready = 1'b0;
    e0 = err_cycles;
    send_frame({8'h11, 8'h11, 8'h11}, 1);
    send_frame({8'h22, 8'h22, 8'h22}, 1);
    wait_cycles(10);
    check("bp_valid_held", 32'(m_valid), 32'h1);
    check("bp_data_kept", 32'(m_data), 32'h111111);
    check("bp_err_count", 32'(err_cycles - e0), 32'd1);
    err_exp += 1;
    exp_q.push_back(24'h111111);
    m_ready = 1'b1;
    wait_cycles(1);
    m_ready = 1'b0;
    wait_cycles(1);
    check("bp_valid_drop", 32'(m_valid), 32'h0);
    check("bp_pending", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 4 of word 1 while a frame is held
    send_frame({8'h5A, 8'h5A, 8'h5A}, 1);
    wait_cycles(10);
    check("rst_pre_valid", 32'(m_valid), 32'h1);
    send_byte(8'h33, 1'b1, 1);
    drive(1'b0, CPP);
    for (int i = 0; i < 4; i++) drive(1'b1, CPP);
    drive(1'b0, 2);
    rstn = 1'b0;
    #1;
    check("rst_mid_valid", 32'(m_valid), 32'h0);
    check("rst_mid_error", 32'(m_error), 32'h0);
    check("rst_mid_data",  32'(m_data),  32'h0);
    rx = 1'b1;
    wait_cycles(5);
    rstn = 1'b1;
    wait_cycles(10);
    m_ready = 1'b1;
    exp_q.push_back(24'hC0FFEE);
    send_frame({8'hC0, 8'hFF, 8'hEE}, 1);
    wait_cycles(10);
    check("rst_fresh_pending", 32'(exp_q.size()), 32'd0);

    check("total_err_count", 32'(err_cycles), 32'(err_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
